// File: rtl/mem_agt_pkg.sv
// Shared definitions for the memory write agent: FSM state encoding and
// the memory-bus address width.
package mem_agt_pkg;

  localparam int ADDR_W = 2;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t BURST = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set bit of valid found by scanning
// upward from ptr and wrapping at NREQ. ptr is expected to be below NREQ.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] valid,
  input  logic [1:0]      ptr,
  output logic [1:0]      index,
  output logic            found
);

  logic [2:0] cand;

  // Scan from the far end back toward ptr so the closest hit is written last.
  always_comb begin
    index = 2'd0;
    found = 1'b0;
    cand  = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + 3'(k);
      if (cand >= 3'(NREQ)) begin
        cand = cand - 3'(NREQ);
      end
      if (valid[cand[1:0]]) begin
        index = cand[1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_wr_arbiter.sv
// Write-path arbiter: NREQ requesters share one memory bus. Ownership is
// granted per burst in round-robin order, and beats leave through a register.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters, req_ready all low
// BURST | owner streams beats until last or MAX_BURST beats have moved
module mem_wr_arbiter
  import mem_agt_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int BW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*BW-1:0]     req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   mem_valid,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [BW-1:0]          mem_data,
  input  logic                   mem_ready,
  output logic [1:0]             grant_id,
  output logic                   busy
);

  state_t            state;
  logic [1:0]        owner;
  logic [1:0]        rr_ptr;
  logic [3:0]        beat_cnt;
  logic [1:0]        pick_idx;
  logic              pick_found;
  logic              own_valid;
  logic              own_last;
  logic [ADDR_W-1:0] own_addr;
  logic [BW-1:0]     own_data;
  logic              bus_free;
  logic              beat_xfer;
  logic              burst_done;
  logic [1:0]        next_ptr;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .index (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_addr  = '0;
    own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == 2'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_addr  = req_addr[i*ADDR_W +: ADDR_W];
        own_data  = req_data[i*BW +: BW];
      end
    end
  end

  // The output register can take a new beat when empty or draining this cycle.
  assign bus_free   = !mem_valid || mem_ready;
  assign beat_xfer  = (state == BURST) && own_valid && bus_free;
  assign burst_done = own_last || (beat_cnt + 4'd1 == 4'(MAX_BURST));
  assign next_ptr   = (owner == 2'(NREQ - 1)) ? 2'd0 : owner + 2'd1;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((state == BURST) && (owner == 2'(i))) begin
        req_ready[i] = bus_free;
      end
    end
  end

  assign grant_id = owner;
  assign busy     = (state == BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 2'd0;
      rr_ptr    <= 2'd0;
      beat_cnt  <= 4'd0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      if (beat_xfer) begin
        mem_valid <= 1'b1;
        mem_addr  <= own_addr;
        mem_data  <= own_data;
      end else if (mem_ready) begin
        mem_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            owner    <= pick_idx;
            beat_cnt <= 4'd0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (beat_xfer) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (burst_done) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_wr_arbiter.md
MEM_WR_ARBITER -- requirements
Module: mem_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..4).
REQ-002 The block SHALL have parameter BW, default 8, giving the data width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the maximum beats per grant (1..15).
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port req_valid, input, NREQ bits: per-requester beat valid.
REQ-007 Port req_last, input, NREQ bits: per-requester last beat of burst.
REQ-008 Port req_addr, input, NREQ*2 bits: per-requester 2-bit address, requester i in bits [2i+1:2i].
REQ-009 Port req_data, input, NREQ*BW bits: per-requester data, requester i in bits [BW*i+BW-1:BW*i].
REQ-010 Port req_ready, output, NREQ bits: per-requester beat accepted.
REQ-011 Port mem_valid, output, 1 bit: memory-bus beat valid.
REQ-012 Port mem_addr, output, 2 bits: memory-bus address.
REQ-013 Port mem_data, output, BW bits: memory-bus data.
REQ-014 Port mem_ready, input, 1 bit: memory-side accept.
REQ-015 Port grant_id, output, 2 bits: index of the current owner.
REQ-016 Port busy, output, 1 bit: high while a grant is held.

Function
REQ-017 FSM SHALL have two states: IDLE and BURST.
REQ-018 In IDLE with any req_valid high, the arbiter SHALL pick the first valid requester scanning round-robin from rr_ptr upward (wrapping at NREQ), latch it as owner, and enter BURST next cycle; req_ready SHALL be 0 in IDLE.
REQ-019 In BURST, req_ready[owner] SHALL equal (!mem_valid || mem_ready); all other req_ready bits SHALL be 0.
REQ-020 A beat SHALL transfer when req_valid[owner] && req_ready[owner]; on transfer, mem_addr/mem_data SHALL load the owner's fields and mem_valid SHALL assert in the next cycle (1-cycle latency).
REQ-021 mem_valid, mem_addr and mem_data SHALL hold stable while mem_valid && !mem_ready; mem_valid SHALL clear after acceptance unless a new beat transfers in the same cycle.
REQ-022 Beat counter SHALL count transfers in the burst (4 bits, reset to 0 on entry to BURST).
REQ-023 Burst SHALL end on a transfer with req_last[owner]=1 or when the counter reaches MAX_BURST; FSM SHALL return to IDLE and set rr_ptr = (owner+1) mod NREQ.
REQ-024 Owner dropping req_valid mid-burst SHALL keep ownership with no timeout; no beat is generated.
REQ-025 A requester other than the owner asserting req_valid SHALL be ignored until the next IDLE arbitration.
REQ-026 grant_id SHALL show owner in BURST and hold its last value in IDLE; busy SHALL be 1 exactly in BURST.
REQ-027 Minimum gap between bursts SHALL be one IDLE cycle.
REQ-028 Beats still pending in the output register at burst end SHALL complete normally; a new burst SHALL not be accepted until req_ready rules permit.

Reset
REQ-029 On rst, FSM SHALL go to IDLE, with rr_ptr=0, owner=0, counter=0, mem_valid=0, mem_addr=0, mem_data=0, req_ready=0, grant_id=0 and busy=0.
REQ-030 Reset asserted mid-burst SHALL discard any pending output beat (mem_valid=0 in the next cycle).

Structure
REQ-031 The shared package mem_agt_pkg SHALL hold the FSM state typedef (IDLE, BURST) and the address width constant (2).
REQ-032 Round-robin selection SHALL be a sub-module rr_pick: combinational inputs valid and ptr, outputs index and found.

Verification
REQ-033 After reset, requesters 0..3 each request one beat with last=1 (data 0x10,0x21,0x32,0x43) -> mem beats in order 0,1,2,3 with the same data, and grant_id 0,1,2,3.
REQ-034 Requester 2 streams 6 beats with no last, mem_ready=1 -> bus shows 4 beats, grant released, then 2 regranted (if alone) for the remaining 2 beats.
REQ-035 With mem_ready held 0 for 3 cycles during a beat (addr 2'b11, data 0xA5) -> mem_valid, mem_addr and mem_data stable for all 3 cycles, req_ready[owner]=0, and the beat is accepted on cycle 4.
REQ-036 Owner 1 drops valid for 5 cycles mid-burst while requester 3 is valid -> grant_id stays 1, and requester 3 is granted only after requester 1 sends last.
REQ-037 rst pulsed while mem_valid=1 in BURST -> next cycle all outputs are 0 and the next grant starts search from requester 0.
